// File: rtl/spi_slave_if.sv
// SPI pins plus the RAM-side word/read-data handshake of the SPI slave.
// The slave modport is the SPI front end; master is its environment.
interface spi_slave_if;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;

  modport slave (
    input  SS_n, MOSI, tx_data, tx_valid,
    output MISO, rx_data, rx_valid
  );

  modport master (
    output SS_n, MOSI, tx_data, tx_valid,
    input  MISO, rx_data, rx_valid
  );
endinterface

// File: rtl/spi_slave.sv
// SPI slave front end: 10-bit MOSI words to RAM, 8-bit read data on MISO.
// SPI bit clock is clk; one word per SS_n frame.
module spi_slave (
  input logic      clk,
  input logic      rst_n,
  spi_slave_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [8:0] rx_shift_q, rx_shift_d;
  logic [9:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic [3:0] tx_cnt_q, tx_cnt_d;
  logic       rd_flag_q, rd_flag_d;
  logic       tx_wait_q, tx_wait_d;
  logic       miso_q, miso_d;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    tx_shift_d = tx_shift_q;
    tx_cnt_d   = tx_cnt_q;
    rd_flag_d  = rd_flag_q;
    tx_wait_d  = tx_wait_q;
    miso_d     = 1'b0;

    // tx_cnt holds the bits still to emit after d7
    if (tx_cnt_q != 4'd0) begin
      miso_d     = tx_shift_q[7];
      tx_shift_d = {tx_shift_q[6:0], 1'b0};
      tx_cnt_d   = tx_cnt_q - 4'd1;
    end
    if (tx_wait_q && bus.tx_valid) begin
      miso_d     = bus.tx_data[7];
      tx_shift_d = {bus.tx_data[6:0], 1'b0};
      tx_cnt_d   = 4'd7;
      tx_wait_d  = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (!bus.SS_n) state_d = CHK_CMD;
      end
      CHK_CMD, WRITE, READ_ADD, READ_DATA: begin
        if (bus.SS_n) begin
          state_d   = IDLE;
          bit_cnt_d = 4'd0;
          tx_cnt_d  = 4'd0;
          tx_wait_d = 1'b0;
          miso_d    = 1'b0;
        end else if (state_q == CHK_CMD) begin
          rx_shift_d = {8'd0, bus.MOSI};
          bit_cnt_d  = 4'd1;
          if (!bus.MOSI)     state_d = WRITE;
          else if (rd_flag_q) state_d = READ_DATA;
          else               state_d = READ_ADD;
        end else if (bit_cnt_q != 4'd10) begin
          rx_shift_d = {rx_shift_q[7:0], bus.MOSI};
          bit_cnt_d  = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd9) begin
            rx_data_d  = {rx_shift_q, bus.MOSI};
            rx_valid_d = 1'b1;
            if (state_q == READ_ADD) rd_flag_d = 1'b1;
            if (state_q == READ_DATA) begin
              rd_flag_d = 1'b0;
              tx_wait_d = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bit_cnt_q  <= 4'd0;
      rx_shift_q <= 9'd0;
      rx_data_q  <= 10'h000;
      rx_valid_q <= 1'b0;
      tx_shift_q <= 8'd0;
      tx_cnt_q   <= 4'd0;
      rd_flag_q  <= 1'b0;
      tx_wait_q  <= 1'b0;
      miso_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_shift_q <= tx_shift_d;
      tx_cnt_q   <= tx_cnt_d;
      rd_flag_q  <= rd_flag_d;
      tx_wait_q  <= tx_wait_d;
      miso_q     <= miso_d;
    end
  end

  assign bus.MISO     = miso_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: drives SPI frames against a small RAM model,
// scoreboards rx words and MISO read bytes.
module tb_spi_slave;

  logic clk = 1'b0;
  logic rst_n;
  logic spur;
  int   n_vec = 0;
  int   n_err = 0;

  spi_slave_if bus ();

  spi_slave dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [256];
  logic [7:0] wr_addr, rd_addr;
  logic [7:0] ram_tx_data;
  logic       ram_tx_valid;

  always @(posedge clk) begin
    if (!rst_n) begin
      ram_tx_valid <= 1'b0;
    end else begin
      ram_tx_valid <= 1'b0;
      if (bus.rx_valid) begin
        case (bus.rx_data[9:8])
          2'b00: wr_addr <= bus.rx_data[7:0];
          2'b01: mem[wr_addr] <= bus.rx_data[7:0];
          2'b10: rd_addr <= bus.rx_data[7:0];
          default: begin
            ram_tx_data  <= mem[rd_addr];
            ram_tx_valid <= 1'b1;
          end
        endcase
      end
    end
  end

  assign bus.tx_valid = ram_tx_valid | spur;
  assign bus.tx_data  = spur ? 8'hFF : ram_tx_data;

  logic [9:0] exp_rx [$];
  logic [7:0] exp_rd [$];

  task automatic chk(input string tag, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.rx_valid) begin
      if (exp_rx.size() == 0)
        chk("rx_unexpected", 32'(bus.rx_data), 32'h3ff_0000);
      else
        chk("rx_data", 32'(bus.rx_data), 32'(exp_rx.pop_front()));
    end
  end

  // nb < 10 aborts the frame after nb bits; spur_at pulses a stray tx_valid
  task automatic send(input logic [9:0] w, input int nb, input bit rd,
                      input int spur_at);
    logic [7:0] b;
    logic       e;
    @(negedge clk);
    bus.SS_n = 1'b0;
    bus.MOSI = 1'b0;
    if (nb == 10) exp_rx.push_back(w);
    for (int i = 0; i < nb; i++) begin
      @(negedge clk);
      chk("miso_rx_phase", 32'(bus.MISO), 32'd0);
      bus.MOSI = w[9-i];
      spur = (i == spur_at);
    end
    if (nb < 10) begin
      @(negedge clk);
      spur = 1'b0;
      bus.SS_n = 1'b1;
      @(negedge clk);
      chk("abort_rx_valid", 32'(bus.rx_valid), 32'd0);
      chk("abort_miso", 32'(bus.MISO), 32'd0);
      return;
    end
    if (rd) begin
      b = exp_rd.pop_front();
      for (int k = 0; k <= 10; k++) begin
        @(negedge clk);
        spur = 1'b0;
        e = (k >= 2 && k <= 9) ? b[9-k] : 1'b0;
        chk("miso_bit", 32'(bus.MISO), 32'(e));
        bus.MOSI = 1'($urandom);
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        spur = 1'b0;
        chk("miso_quiet", 32'(bus.MISO), 32'd0);
        bus.MOSI = 1'($urandom);
      end
    end
    chk("rx_hold", 32'(bus.rx_data), 32'(w));
    bus.SS_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    spur     = 1'b0;
    bus.SS_n = 1'b0;
    bus.MOSI = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("rst_miso", 32'(bus.MISO), 32'd0);
      chk("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
      chk("rst_rx_data", 32'(bus.rx_data), 32'd0);
      bus.MOSI = ~bus.MOSI;
    end
    rst_n    = 1'b1;
    bus.SS_n = 1'b1;

    send(10'h03C, 10, 1'b0, -1);
    send(10'h1A5, 10, 1'b0, -1);
    send(10'h23C, 10, 1'b0, -1);
    exp_rd.push_back(8'hA5);
    send(10'h300, 10, 1'b1, -1);

    send(10'h0F0, 5, 1'b0, -1);
    send(10'h011, 10, 1'b0, -1);

    send(10'h23C, 10, 1'b0, -1);
    send(10'h3FF, 5, 1'b0, -1);
    exp_rd.push_back(8'hA5);
    send(10'h300, 10, 1'b1, -1);
    send(10'h23C, 10, 1'b0, -1);
    exp_rd.push_back(8'hA5);
    send(10'h300, 10, 1'b1, -1);

    send(10'h020, 10, 1'b0, 4);
    send(10'h15A, 10, 1'b0, 7);
    send(10'h220, 10, 1'b0, -1);
    exp_rd.push_back(8'h5A);
    send(10'h300, 10, 1'b1, -1);
    send(10'h23C, 10, 1'b0, -1);
    exp_rd.push_back(8'hA5);
    send(10'h3C3, 10, 1'b1, -1);

    repeat (3) @(negedge clk);
    chk("rx_queue_empty", 32'(exp_rx.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
# spi_slave

Serial-to-parallel SPI slave front end of the SPI/RAM subsystem. It receives 10-bit command/data words on MOSI while SS_n is low and presents each complete word to the downstream single-port RAM as rx_data with a one-cycle rx_valid strobe. On a read-data command it waits for the RAM's tx_valid/tx_data response and shifts the 8-bit result out on MISO, MSB first. The SPI bit clock is the system clock clk.

## Interface
- No parameters; word width 10, read-data width 8, fixed.
- clk  in  1  system clock, also the SPI bit clock; all sampling on rising edge
- rst_n  in  1  reset, synchronous, active-low
- SS_n  in  1  slave select, active-low; frame delimiter
- MOSI  in  1  serial data from master, MSB first
- MISO  out  1  serial data to master, MSB first; 0 when not shifting
- rx_data  out  10  received word to RAM; [9:8] command, [7:0] address/data
- rx_valid  out  1  one-cycle strobe, rx_data valid
- tx_data  in  8  read data from RAM
- tx_valid  in  1  RAM read-data valid strobe

## Operation
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA. Internal: 4-bit bit counter, 10-bit RX shift register, 8-bit TX shift register, 4-bit TX counter, rd_addr_flag, tx_wait flag.
- IDLE: SS_n=0 -> CHK_CMD; otherwise stay.
- CHK_CMD: sample MOSI as word bit 9. SS_n=1 -> IDLE. MOSI=0 -> WRITE. MOSI=1 and rd_addr_flag=0 -> READ_ADD. MOSI=1 and rd_addr_flag=1 -> READ_DATA.
- WRITE / READ_ADD / READ_DATA: shift in 9 more bits (bits 8..0), one per cycle, MSB first. On the edge sampling bit 0: rx_data <= full 10-bit word, rx_valid <= 1 for one cycle. Bits are forwarded exactly as received; state only governs routing and the flag.
- READ_ADD completion (rx_valid issued): rd_addr_flag <= 1.
- READ_DATA completion: rd_addr_flag <= 0, tx_wait <= 1.
- tx_wait=1 and tx_valid=1: TX shift register <= tx_data, MISO <= tx_data[7], tx_wait <= 0; then bits 6..0 on the next 7 edges; on the following edge MISO <= 0.
- tx_valid ignored when tx_wait=0. Only the first tx_valid per read is captured.
- After a word completes (and any MISO shift ends), the FSM stays in its data state, ignoring MOSI, until SS_n=1. One word per frame.
- SS_n=1 in any non-IDLE state: next edge -> IDLE; bit counter, TX counter, tx_wait cleared; MISO <= 0; partial word discarded, no rx_valid. rd_addr_flag retained.
- Reset (rst_n=0 at edge): state IDLE, rx_data 10'h000, rx_valid 0, MISO 0, rd_addr_flag 0, tx_wait 0, all counters 0. Reset has priority over every other input.

## Timing
- Edge E0: SS_n=0 sampled in IDLE -> CHK_CMD.
- E1: bit 9 sampled. E2..E10: bits 8..0 sampled.
- rx_valid high from E10 to E11 (exactly one cycle); rx_data stable from E10 until next word.
- With RAM registering on rx_valid, tx_valid is high E11-E12; captured at E12; MISO = d7 after E12, d0 after E19, 0 after E20.
- Read latency, last MOSI bit to first MISO bit: 2 cycles (with 1-cycle RAM).
- SS_n must stay low through E20 for a complete read; raising it earlier aborts MISO output at the next edge.
- Minimum SS_n high between frames: 1 cycle.

## Test plan
- Reset: rst_n=0 for 2 cycles with SS_n=0, MOSI toggling -> MISO=0, rx_valid=0, rx_data=0, state IDLE; release -> first frame accepted normally.
- Write address + data: frame 00_0x3C, then frame 01_0xA5 -> rx_valid pulses at E10 of each with rx_data=10'h03C then 10'h1A5; MISO stays 0.
- Read sequence: frame 10_0x3C -> rx_data=10'h23C, rd_addr_flag=1; frame 11_0x00 with RAM returning 0xA5 -> rx_data=10'h300, MISO emits 1,0,1,0,0,1,0,1 on E12..E19, then 0; rd_addr_flag=0.
- Abort: SS_n raised after 5 bits of a write frame -> no rx_valid, IDLE next edge; following full frame 00_0x11 -> rx_data=10'h011.
- Flag persistence: READ_ADD frame, aborted READ_DATA frame (SS_n high at E6) -> next frame starting with MOSI=1 still routes to READ_DATA; completed read clears flag.
- Spurious tx_valid: pulse tx_valid with tx_data=0xFF during a write frame -> MISO remains 0, no effect on later read data.
